// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, default widths and error read value for dmem_bridge.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TIMEOUT_DEF = 16;
  localparam int ERR_RDATA = 0;
endpackage

// File: rtl/dmem_timeout_ctr.sv
// dmem_timeout_ctr: counts BUSY cycles and flags the cycle in which the access must be abandoned.
module dmem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  assign expire = en && (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: CPU load/store to single-outstanding memory bus bridge with timeout.
// Optional misaligned-access rejection when DMEM_BRIDGE_ALIGN_CHECK_EN is defined.
module dmem_bridge import dmem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  state_t state;
  logic   expire;
  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk_i), .rst(rst_i), .clr(state != BUSY), .en(state == BUSY), .expire(expire)
  );
  // Bus request is a pure decode of state so an async reset drops it at once.
  assign mem_req_o = state == BUSY;
  assign stall_o = (state == BUSY) || (state == IDLE && req_i);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state       <= IDLE;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          mem_we_o    <= we_i;
          mem_addr_o  <= addr_i;
          mem_wdata_o <= wdata_i;
`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
          if (addr_i[1:0] != 2'b00) begin
            state   <= DONE;
            err_o   <= 1'b1;
            rdata_o <= DATA_W'(ERR_RDATA);
          end else state <= BUSY;
`else
          state <= BUSY;
`endif
        end
        BUSY: if (mem_ack_i) begin
          if (!mem_we_o) rdata_o <= mem_rdata_i;
          state <= DONE;
        end else if (expire) begin
          err_o   <= 1'b1;
          rdata_o <= DATA_W'(ERR_RDATA);
          state   <= DONE;
        end
        DONE: begin
          err_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed checks of dmem_bridge (TIMEOUT 16 instance a, TIMEOUT 4 instance b).
module tb_dmem_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, mrdata = '0;
  logic req_a = 1'b0, ack_a = 1'b0, req_b = 1'b0, ack_b = 1'b0;
  logic [31:0] rdata_a, maddr_a, mwdata_a, rdata_b, maddr_b, mwdata_b;
  logic stall_a, err_a, mreq_a, mwe_a, stall_b, err_b, mreq_b, mwe_b;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  dmem_bridge dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata_a), .stall_o(stall_a), .err_o(err_a), .mem_req_o(mreq_a), .mem_we_o(mwe_a),
    .mem_addr_o(maddr_a), .mem_wdata_o(mwdata_a), .mem_ack_i(ack_a), .mem_rdata_i(mrdata)
  );
  dmem_bridge #(.TIMEOUT(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata_b), .stall_o(stall_b), .err_o(err_b), .mem_req_o(mreq_b), .mem_we_o(mwe_b),
    .mem_addr_o(maddr_b), .mem_wdata_o(mwdata_b), .mem_ack_i(ack_b), .mem_rdata_i(mrdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  initial begin
    #2;
    chk("rst_mem_req", 32'(mreq_a), 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_stall", 32'(stall_a), 32'd0);
    chk("rst_mem_addr", maddr_a, 32'd0);
    tick();
    rst = 1'b0;
    // load 0x10, ack in first BUSY cycle
    req_a = 1'b1; we = 1'b0; addr = 32'h10; #1;
    chk("ld_idle_stall", 32'(stall_a), 32'd1);
    chk("ld_idle_mreq", 32'(mreq_a), 32'd0);
    tick();
    ack_a = 1'b1; mrdata = 32'hCAFEF00D; #1;
    chk("ld_busy_stall", 32'(stall_a), 32'd1);
    chk("ld_busy_mreq", 32'(mreq_a), 32'd1);
    chk("ld_busy_addr", maddr_a, 32'h10);
    chk("ld_busy_we", 32'(mwe_a), 32'd0);
    tick();
    ack_a = 1'b0; req_a = 1'b0;
    chk("ld_done_stall", 32'(stall_a), 32'd0);
    chk("ld_done_mreq", 32'(mreq_a), 32'd0);
    chk("ld_done_rdata", rdata_a, 32'hCAFEF00D);
    chk("ld_done_err", 32'(err_a), 32'd0);
    tick();
    // store 0x20, req dropped during BUSY, ack in 5th BUSY cycle
    req_a = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    tick();
    req_a = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; mrdata = 32'hDEADBEEF;
    for (int i = 1; i <= 5; i++) begin
      ack_a = (i == 5); #1;
      chk($sformatf("st_busy%0d_mreq", i), 32'(mreq_a), 32'd1);
      chk($sformatf("st_busy%0d_stall", i), 32'(stall_a), 32'd1);
      chk($sformatf("st_busy%0d_addr", i), maddr_a, 32'h20);
      chk($sformatf("st_busy%0d_wdata", i), mwdata_a, 32'h12345678);
      chk($sformatf("st_busy%0d_we", i), 32'(mwe_a), 32'd1);
      tick();
    end
    ack_a = 1'b0;
    chk("st_done_rdata", rdata_a, 32'hCAFEF00D);
    chk("st_done_err", 32'(err_a), 32'd0);
    chk("st_done_stall", 32'(stall_a), 32'd0);
    tick();
    // TIMEOUT=4: ack coincident with final timeout cycle wins
    req_b = 1'b1; we = 1'b0; addr = 32'h40;
    tick();
    for (int i = 1; i <= 4; i++) begin
      ack_b = (i == 4); mrdata = 32'h1; #1;
      chk($sformatf("co_busy%0d_mreq", i), 32'(mreq_b), 32'd1);
      tick();
    end
    ack_b = 1'b0; req_b = 1'b0;
    chk("co_done_err", 32'(err_b), 32'd0);
    chk("co_done_rdata", rdata_b, 32'h1);
    tick();
    // TIMEOUT=4 with no ack
    req_b = 1'b1; addr = 32'h44;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_busy%0d_mreq", i), 32'(mreq_b), 32'd1);
      tick();
    end
    req_b = 1'b0;
    chk("to_done_err", 32'(err_b), 32'd1);
    chk("to_done_rdata", rdata_b, 32'd0);
    chk("to_done_mreq", 32'(mreq_b), 32'd0);
    chk("to_done_stall", 32'(stall_b), 32'd0);
    tick();
    chk("to_idle_err", 32'(err_b), 32'd0);
    // async reset in 2nd BUSY cycle
    req_a = 1'b1; addr = 32'h30;
    tick();
    tick();
    chk("rb_busy2_mreq", 32'(mreq_a), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rb_async_mreq", 32'(mreq_a), 32'd0);
    chk("rb_async_stall_follows_req", 32'(stall_a), 32'd1);
    chk("rb_async_rdata", rdata_a, 32'd0);
    chk("rb_async_addr", maddr_a, 32'd0);
    req_a = 1'b0;
    tick();
    rst = 1'b0; ack_a = 1'b1; mrdata = 32'h00000BAD; #1;
    chk("rb_stray_mreq", 32'(mreq_a), 32'd0);
    tick();
    ack_a = 1'b0;
    chk("rb_stray_rdata", rdata_a, 32'd0);
    chk("rb_stray_err", 32'(err_a), 32'd0);
    chk("rb_stray_mreq2", 32'(mreq_a), 32'd0);
    // misaligned load 0x13
    req_a = 1'b1; we = 1'b0; addr = 32'h13; #1;
    chk("ma_idle_mreq", 32'(mreq_a), 32'd0);
    tick();
`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
    req_a = 1'b0;
    chk("ma_done_mreq", 32'(mreq_a), 32'd0);
    chk("ma_done_err", 32'(err_a), 32'd1);
    chk("ma_done_rdata", rdata_a, 32'd0);
    chk("ma_done_stall", 32'(stall_a), 32'd0);
`else
    ack_a = 1'b1; mrdata = 32'h55; #1;
    chk("ma_busy_mreq", 32'(mreq_a), 32'd1);
    chk("ma_busy_addr", maddr_a, 32'h13);
    tick();
    ack_a = 1'b0; req_a = 1'b0;
    chk("ma_done_rdata", rdata_a, 32'h55);
    chk("ma_done_err", 32'(err_a), 32'd0);
`endif
    tick();
    // back-to-back: accepted in the IDLE cycle right after DONE
    req_a = 1'b1; addr = 32'h8; #1;
    chk("bb_idle_stall", 32'(stall_a), 32'd1);
    tick();
    ack_a = 1'b1; mrdata = 32'h77; #1;
    chk("bb_busy_mreq", 32'(mreq_a), 32'd1);
    chk("bb_busy_addr", maddr_a, 32'h8);
    tick();
    ack_a = 1'b0; req_a = 1'b0;
    chk("bb_done_rdata", rdata_a, 32'h77);
    chk("bb_done_err", 32'(err_a), 32'd0);
    tick();
    chk("bb_idle_mreq", 32'(mreq_a), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width on both sides.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter TIMEOUT, default 16, maximum BUSY cycles before an access is abandoned; legal range 1..255.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 req_i  input  1  CPU load/store request, held high by the CPU until stall_o is low.
REQ-007 we_i  input  1  1 = store, 0 = load; valid with req_i.
REQ-008 addr_i  input  ADDR_W  ALU result used as the byte address.
REQ-009 wdata_i  input  DATA_W  store data (register-file RT value).
REQ-010 rdata_o  output  DATA_W  load data returned to the write-back mux.
REQ-011 stall_o  output  1  freezes the program counter and register-file write while high.
REQ-012 err_o  output  1  access failed (timeout, or misalignment when that check is enabled).
REQ-013 mem_req_o  output  1  bus request.
REQ-014 mem_we_o  output  1  bus write enable.
REQ-015 mem_addr_o  output  ADDR_W  bus address.
REQ-016 mem_wdata_o  output  DATA_W  bus write data.
REQ-017 mem_ack_i  input  1  bus completion; one-cycle pulse.
REQ-018 mem_rdata_i  input  DATA_W  read data, valid when mem_ack_i is high.

Function
REQ-019 FSM states: IDLE, BUSY, DONE.
REQ-020 IDLE with req_i=1: latch we_i, addr_i and wdata_i, then go to BUSY; stall_o=1 combinationally in that same cycle.
REQ-021 BUSY: mem_req_o=1 and stall_o=1; mem_we_o, mem_addr_o and mem_wdata_o are driven from the latched values and stay stable until ack or timeout.
REQ-022 BUSY with mem_ack_i=1: capture mem_rdata_i into rdata_o for a load (hold rdata_o unchanged for a store) and go to DONE; the earliest ack is the first BUSY cycle, giving 2-cycle latency.
REQ-023 BUSY timeout counter: cleared on entry to BUSY, incremented each BUSY cycle; when it reaches TIMEOUT-1 with no ack, go to DONE with err_o=1 and rdata_o=0.
REQ-024 If mem_ack_i and the timeout coincide in one cycle, the ack wins and err_o=0.
REQ-025 DONE: stall_o=0, mem_req_o=0; rdata_o and err_o are valid for exactly this cycle; next state is IDLE regardless of req_i.
REQ-026 mem_ack_i outside BUSY is ignored.
REQ-027 req_i dropping while in BUSY does not abort the access.
REQ-028 Back-to-back accesses: a new req_i is accepted in the IDLE cycle after DONE, so the minimum spacing is 3 cycles.
REQ-029 err_o is cleared when leaving DONE.

Reset
REQ-030 rst_i asserted forces IDLE immediately, including mid-BUSY; mem_req_o drops without waiting for the clock.
REQ-031 Reset values: rdata_o=0, err_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, timeout counter=0; stall_o then follows req_i through REQ-020.
REQ-032 An ack arriving in the first cycle after reset release is ignored per REQ-026.

Configuration
REQ-033 Macro DMEM_BRIDGE_ALIGN_CHECK_EN.
REQ-034 Defined: IDLE with req_i=1 and addr_i[1:0]!=0 goes straight to DONE with err_o=1 and rdata_o=0; no bus request is issued.
REQ-035 Undefined: there is no alignment check; addr_i[1:0] pass through to mem_addr_o unchanged.

Structure
REQ-036 Shared package dmem_pkg holds the state enum type (IDLE/BUSY/DONE), the default width constants, and the error read value 0.
REQ-037 One sub-module, dmem_timeout_ctr: clear, enable and expire outputs, parameterised by TIMEOUT.

Verification
REQ-038 Load at addr 0x10, ack in the first BUSY cycle with data 0xCAFEF00D: stall_o is high for 2 cycles, then DONE shows rdata_o=0xCAFEF00D and err_o=0.
REQ-039 Store at addr 0x20 with data 0x12345678, ack after 5 BUSY cycles: mem_addr_o=0x20, mem_wdata_o=0x12345678 and mem_we_o=1 stay stable for all 5 cycles; rdata_o is unchanged.
REQ-040 TIMEOUT=4 with no ack: DONE follows the 4th BUSY cycle with err_o=1 and rdata_o=0; mem_req_o is low in DONE.
REQ-041 Ack coincident with the final timeout cycle, data 0x1: err_o=0 and rdata_o=0x1.
REQ-042 rst_i pulsed in the 2nd BUSY cycle: mem_req_o goes low asynchronously; after release the FSM is in IDLE and a stray ack causes no change.
REQ-043 With DMEM_BRIDGE_ALIGN_CHECK_EN defined, a load at addr 0x13: no mem_req_o pulse, DONE in the next cycle with err_o=1; with the macro undefined, a bus access to 0x13 occurs.
